// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-back arbiter merging the pipeline stream
// with a long-latency result FIFO; `define WB_PENDING_CHECK_EN adds pend ports.
module wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_we,
    input  logic [4:0]  p_wa,
    input  logic [31:0] p_wd,
    input  logic        l_valid,
    output logic        l_ready,
    input  logic [4:0]  l_wa,
    input  logic [31:0] l_wd,
    output logic        stall,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3
`ifdef WB_PENDING_CHECK_EN
    ,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        pend1,
    output logic        pend2
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [4:0]       ewa_q [DEPTH];
    logic [4:0]       ewa_d [DEPTH];
    logic [31:0]      ewd_q [DEPTH];
    logic [31:0]      ewd_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             stall_q, stall_d;
    logic             we3_q, we3_d;
    logic [4:0]       wa3_q, wa3_d;
    logic [31:0]      wd3_q, wd3_d;
    logic             live, push, pop, empty;

    assign l_ready = (count_q != FULL);
    assign stall   = stall_q;
    assign we3     = we3_q;
    assign wa3     = wa3_q;
    assign wd3     = wd3_q;

    // Source select, kill of stale FIFO entries, FIFO bookkeeping, starvation.
    always_comb begin
        live   = p_we && (p_wa != 5'd0);
        empty  = (count_q == '0);
        push   = l_valid && l_ready && (l_wa != 5'd0);
        pop    = !live && !empty;
        vld_d  = vld_q;
        ewa_d  = ewa_q;
        ewd_d  = ewd_q;
        head_d = head_q;
        tail_d = tail_q;
        we3_d  = 1'b0;
        wa3_d  = wa3_q;
        wd3_d  = wd3_q;
        if (live) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ewa_q[i] == p_wa) begin
                    vld_d[i] = 1'b0;
                end
            end
            we3_d = 1'b1;
            wa3_d = p_wa;
            wd3_d = p_wd;
        end else if (pop) begin
            we3_d = vld_q[head_q];
            if (vld_q[head_q]) begin
                wa3_d = ewa_q[head_q];
                wd3_d = ewd_q[head_q];
            end
            vld_d[head_q] = 1'b0;
            head_d = head_q + 1'b1;
        end
        if (push) begin
            vld_d[tail_q] = !(live && (l_wa == p_wa));
            ewa_d[tail_q] = l_wa;
            ewd_d[tail_q] = l_wd;
            tail_d = tail_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
        stall_d = (starve_q >= SMAX);
        if (empty || pop) begin
            starve_d = '0;
        end else if (starve_q != SMAX) begin
            starve_d = starve_q + 1'b1;
        end else begin
            starve_d = starve_q;
        end
    end

    // State registers; reset drops all buffered results at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ewa_q[i] <= '0;
                ewd_q[i] <= '0;
            end
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            we3_q    <= 1'b0;
            wa3_q    <= '0;
            wd3_q    <= '0;
        end else begin
            vld_q    <= vld_d;
            ewa_q    <= ewa_d;
            ewd_q    <= ewd_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            we3_q    <= we3_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
        end
    end

`ifdef WB_PENDING_CHECK_EN
    // Flag decode reads whose register still has a write in flight.
    always_comb begin
        pend1 = we3_q && (wa3_q == ra1);
        pend2 = we3_q && (wa3_q == ra2);
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (ewa_q[i] == ra1)) begin
                pend1 = 1'b1;
            end
            if (vld_q[i] && (ewa_q[i] == ra2)) begin
                pend2 = 1'b1;
            end
        end
        if (ra1 == 5'd0) begin
            pend1 = 1'b0;
        end
        if (ra2 == 5'd0) begin
            pend2 = 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter with a queue-based
// reference model, directed scenarios and randomized traffic.
module tb_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_we;
    logic [4:0]  p_wa;
    logic [31:0] p_wd;
    logic        l_valid;
    logic        l_ready;
    logic [4:0]  l_wa;
    logic [31:0] l_wd;
    logic        stall;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
`ifdef WB_PENDING_CHECK_EN
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        pend1;
    logic        pend2;
    logic [4:0]  ra1_sel = 5'd0;
    logic [4:0]  ra2_sel = 5'd0;
`endif

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .p_we(p_we), .p_wa(p_wa), .p_wd(p_wd),
        .l_valid(l_valid), .l_ready(l_ready),
        .l_wa(l_wa), .l_wd(l_wd),
        .stall(stall),
        .we3(we3), .wa3(wa3), .wd3(wd3)
`ifdef WB_PENDING_CHECK_EN
        , .ra1(ra1), .ra2(ra2), .pend1(pend1), .pend2(pend2)
`endif
    );

    typedef struct {
        bit          v;
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    // Reference model: buffered results in arrival order, expected writes.
    ent_t        mq[$];
    wr_t         exp_q[$];
    bit          m_we;
    logic [4:0]  m_wa3;
    logic [31:0] m_wd3;
    int          m_cnt;
    bit          m_stall;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic bit m_pend(logic [4:0] ra);
        if (ra == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].v && mq[i].wa == ra) return 1'b1;
        return m_we && (m_wa3 == ra);
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_we    = 1'b0;
        m_wa3   = '0;
        m_wd3   = '0;
        m_cnt   = 0;
        m_stall = 1'b0;
    endtask

    // Monitor: every register-file write must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && we3 === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: wa3=%0d wd3=%0h, none expected",
                         wa3, wd3);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wa3", 32'(wa3), 32'(w.wa));
                check("wd3", wd3, w.wd);
            end
        end
    end

    // One clock: compare visible state, drive inputs, advance the model.
    task automatic cycle(bit pwe, logic [4:0] pwa, logic [31:0] pwd,
                         bit lv, logic [4:0] lwa, logic [31:0] lwd);
        bit   live;
        bit   acc;
        int   pre;
        ent_t h;
        ent_t e;
        wr_t  w;
        @(negedge clk);
        check("we3", 32'(we3), 32'(m_we));
        check("l_ready", 32'(l_ready), 32'(mq.size() < DEPTH));
        check("stall", 32'(stall), 32'(m_stall));
`ifdef WB_PENDING_CHECK_EN
        check("pend1", 32'(pend1), 32'(m_pend(ra1)));
        check("pend2", 32'(pend2), 32'(m_pend(ra2)));
        ra1 = ra1_sel;
        ra2 = ra2_sel;
`endif
        p_we = pwe; p_wa = pwa; p_wd = pwd;
        l_valid = lv; l_wa = lwa; l_wd = lwd;
        live = pwe && (pwa != 5'd0);
        acc  = lv && (mq.size() < DEPTH);
        pre  = mq.size();
        if (live) begin
            foreach (mq[i]) if (mq[i].wa == pwa) mq[i].v = 1'b0;
            m_we = 1'b1; m_wa3 = pwa; m_wd3 = pwd;
            w.wa = pwa; w.wd = pwd;
            exp_q.push_back(w);
        end else if (pre > 0) begin
            h = mq.pop_front();
            m_we = h.v;
            if (h.v) begin
                m_wa3 = h.wa; m_wd3 = h.wd;
                w.wa = h.wa; w.wd = h.wd;
                exp_q.push_back(w);
            end
        end else begin
            m_we = 1'b0;
        end
        if (acc && lwa != 5'd0) begin
            e.v  = !(live && lwa == pwa);
            e.wa = lwa;
            e.wd = lwd;
            mq.push_back(e);
        end
        m_stall = (m_cnt >= SMAX);
        if (pre == 0 || !live) m_cnt = 0;
        else if (m_cnt < SMAX) m_cnt++;
    endtask

    task automatic idle(int n);
        repeat (n) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic mid_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_we3", 32'(we3), 32'd0);
        check("rst_wa3", 32'(wa3), 32'd0);
        check("rst_wd3", wd3, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_l_ready", 32'(l_ready), 32'd1);
`ifdef WB_PENDING_CHECK_EN
        check("rst_pend1", 32'(pend1), 32'd0);
`endif
        model_reset();
        p_we = 1'b0;
        l_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        p_we = 1'b0; p_wa = '0; p_wd = '0;
        l_valid = 1'b0; l_wa = '0; l_wd = '0;
`ifdef WB_PENDING_CHECK_EN
        ra1 = '0; ra2 = '0;
`endif
        model_reset();
        #1;
        check("reset_we3", 32'(we3), 32'd0);
        check("reset_wa3", 32'(wa3), 32'd0);
        check("reset_wd3", wd3, 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_l_ready", 32'(l_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Single pipeline write, then a bubble.
        cycle(1'b1, 5'd1, 32'd10, 1'b0, 5'd0, 32'd0);
        idle(2);

        // Writes to r0 from either source are discarded.
        cycle(1'b1, 5'd0, 32'h1111, 1'b0, 5'd0, 32'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h2222);
        idle(2);

        // Fill the FIFO behind a continuous pipeline stream, starve, drain.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 5'd9, 32'h900 + i, 1'b1, 5'(2 + i), 32'hA0 + i);
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 5'd9, 32'h990 + i, 1'b0, 5'd0, 32'd0);
        idle(7);

        // Newer pipeline value kills a buffered result to the same register.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAAAA);
        cycle(1'b1, 5'd7, 32'h5555, 1'b0, 5'd0, 32'd0);
        idle(3);

        // Same-cycle result and pipeline write to one register.
        cycle(1'b1, 5'd6, 32'h6666, 1'b1, 5'd6, 32'h7777);
        idle(3);

`ifdef WB_PENDING_CHECK_EN
        ra1_sel = 5'd12;
        ra2_sel = 5'd0;
        cycle(1'b1, 5'd9, 32'h1, 1'b1, 5'd12, 32'hC);
        cycle(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0);
        idle(4);
        cycle(1'b1, 5'd9, 32'h3, 1'b1, 5'd12, 32'hD);
        cycle(1'b1, 5'd9, 32'h4, 1'b1, 5'd13, 32'hE);
        idle(1);
        ra1_sel = 5'd0;
`else
        cycle(1'b1, 5'd9, 32'h3, 1'b1, 5'd12, 32'hD);
        cycle(1'b1, 5'd9, 32'h4, 1'b1, 5'd13, 32'hE);
        idle(1);
`endif
        mid_reset();
        idle(3);

        // Randomized traffic; upstream mostly honours stall.
        for (int n = 0; n < 2000; n++) begin
            bit pwe;
            bit lv;
            pwe = ($urandom_range(0, 99) < 60);
            if (m_stall && $urandom_range(0, 3) != 0) pwe = 1'b0;
            lv = ($urandom_range(0, 99) < 45);
`ifdef WB_PENDING_CHECK_EN
            ra1_sel = 5'($urandom_range(0, 7));
            ra2_sel = 5'($urandom_range(0, 7));
`endif
            cycle(pwe, 5'($urandom_range(0, 7)), $urandom,
                  lv, 5'($urandom_range(0, 7)), $urandom);
            if (n == 1000) mid_reset();
        end

        idle(12);
        @(negedge clk);
        #1;
        check("exp_drain", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter sitting directly upstream of the register file's single write port (we3/wa3/wd3). It merges the in-order pipeline write-back stream with results from long-latency units (multiply/divide, load-miss return) buffered in a small FIFO. It enforces newest-value-wins ordering per destination register and filters writes to r0. It raises a stall request toward the pipeline when buffered results starve.

## Interface
- DEPTH, 4: long-latency FIFO entries (power of two, 2..16)
- STARVE_MAX, 8: cycles a FIFO head may wait before `stall` asserts
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- p_we  in  1  pipeline write-back valid (never back-pressured)
- p_wa  in  5  pipeline destination register
- p_wd  in  32  pipeline write data
- l_valid  in  1  long-latency result valid
- l_ready  out  1  FIFO can accept; transfer when l_valid && l_ready
- l_wa  in  5  long-latency destination register
- l_wd  in  32  long-latency write data
- stall  out  1  request: upstream must hold p_we=0 next cycle
- we3  out  1  register-file write enable (registered)
- wa3  out  5  register-file write address (registered)
- wd3  out  32  register-file write data (registered)
- ra1, ra2  in  5  decode read addresses (only with WB_PENDING_CHECK_EN)
- pend1, pend2  out  1  read address has a write in flight (only with WB_PENDING_CHECK_EN)

## Operation
- Pipeline write is "live" when p_we && p_wa!=0; p_wa==0 writes are discarded.
- Each cycle, select exactly one source for the output register: live pipeline write has absolute priority; otherwise pop FIFO head if a valid entry exists; otherwise we3<=0 (wa3/wd3 hold).
- FIFO: DEPTH entries {valid, wa, wd}, head/tail pointers wrap modulo DEPTH, count 0..DEPTH.
- l_ready = (count < DEPTH); no accept-while-full even if a pop occurs that cycle.
- Accepted result with l_wa==0: handshake completes, nothing enqueued.
- Kill rule: live pipeline write to X clears `valid` of every FIFO entry with wa==X, including an entry being enqueued the same cycle (same-cycle long-latency result is older, dropped).
- Killed entries still occupy slots; pop of an invalid head produces we3<=0 and frees the slot (slot consumed, no write). Pop only happens in cycles with no live pipeline write.
- Starvation counter: increments each cycle FIFO non-empty and pop blocked by a live pipeline write; clears on any pop or when empty. stall = (counter >= STARVE_MAX). Counter saturates.
- If upstream ignores stall, pipeline still wins; no data loss, stall stays high.

## Timing
- Reset values: we3=0, wa3=0, wd3=0, stall=0, l_ready=1, count=0, pointers=0, all entry valids=0, counter=0, pend1=pend2=0.
- Pipeline path latency: p_we sampled at edge N -> we3/wa3/wd3 valid after edge N; register file writes at edge N+1.
- Long-latency path: accepted at edge N (empty FIFO, no pipeline write at N+1 cycle) -> we3 valid after edge N+1; earliest rf write edge N+2.
- Simultaneous push and pop with count<DEPTH: both take effect; count unchanged.
- Reset asserted mid-operation: all buffered results discarded immediately, outputs go to reset values asynchronously.
- stall is registered from counter; it rises the cycle after the counter reaches STARVE_MAX.

## Configuration
- WB_PENDING_CHECK_EN defined: ra1/ra2/pend1/pend2 ports exist; pendN = (raN!=0) && (raN matches a valid FIFO entry's wa, or we3 && wa3==raN); combinational. Decode uses it to stall reads of in-flight registers.
- Undefined: ports absent, no comparators synthesized; all other behaviour identical.

## Test plan
- Reset then p_we=1,p_wa=1,p_wd=10 for one cycle -> next cycle we3=1,wa3=1,wd3=10; following cycle we3=0.
- p_wa=0 with p_we=1 -> we3 stays 0; l_wa=0 accepted -> count unchanged, we3 never asserts.
- Push 4 results (regs 2..5) with continuous pipeline writes to r9 -> l_ready=0 after 4th; stall=1 after 8 blocked cycles; drop p_we -> writes r2,r3,r4,r5 in order on consecutive cycles, l_ready returns 1.
- Enqueue l_wa=7 data 0xAAAA, then pipeline write r7 data 0x5555 -> rf sees only 0x5555; killed slot drains with we3=0.
- Same-cycle l_valid(l_wa=6) and p_we(p_wa=6) -> only pipeline value written; count returns to 0 after one idle cycle.
- With WB_PENDING_CHECK_EN: enqueue r12, ra1=12 -> pend1=1 until the cycle after the write of r12 leaves wa3; ra2=0 -> pend2=0 always; assert rst mid-drain -> pend1=0, we3=0 immediately.
